// File: rtl/spi_xfer_ctrl_if.sv
// spi_xfer_ctrl_if: host and byte-core handshake bundle for spi_xfer_ctrl
// Host side : i_Start, i_Len, i_TX_Word -> o_Busy, o_Done, o_RX_Word
// Core side : o_TX_Byte, o_TX_DV -> i_TX_Ready, i_RX_DV, i_RX_Byte
// Chip sel  : o_SPI_CS_n (active low)
// slave modport is the controller; master modport is its environment.
interface spi_xfer_ctrl_if;
  logic        i_Start;
  logic [2:0]  i_Len;
  logic [31:0] i_TX_Word;
  logic        o_Busy;
  logic        o_Done;
  logic [31:0] o_RX_Word;
  logic [7:0]  o_TX_Byte;
  logic        o_TX_DV;
  logic        i_TX_Ready;
  logic        i_RX_DV;
  logic [7:0]  i_RX_Byte;
  logic        o_SPI_CS_n;
  modport slave (
    input  i_Start, i_Len, i_TX_Word, i_TX_Ready, i_RX_DV, i_RX_Byte,
    output o_Busy, o_Done, o_RX_Word, o_TX_Byte, o_TX_DV, o_SPI_CS_n
  );
  modport master (
    output i_Start, i_Len, i_TX_Word, i_TX_Ready, i_RX_DV, i_RX_Byte,
    input  o_Busy, o_Done, o_RX_Word, o_TX_Byte, o_TX_DV, o_SPI_CS_n
  );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: multi-byte SPI transaction sequencer with chip-select timing
// i_Clk, i_Rst : rising-edge clock, asynchronous active-high reset
// bus (slave)  : host request/response, byte handshake to the SPI master core, CS_n
// Sends 1..4 bytes MSB-first from the low 8*Len bits of i_TX_Word and
// returns the received bytes right-justified in o_RX_Word.
module spi_xfer_ctrl #(
  parameter int CS_LEAD_CLKS = 2,
  parameter int CS_LAG_CLKS  = 2,
  parameter int CS_IDLE_CLKS = 2
) (
  input logic i_Clk,
  input logic i_Rst,
  spi_xfer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CS_LEAD, SEND, WAIT_RX, CS_LAG, CS_IDLE} state_t;
  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  rem;
  logic [31:0] tx_q;
  logic [31:0] rx_q;
  logic [7:0]  next_byte;
  // rem counts down from Len, so the next byte sits at bits [8*rem-1 -: 8]
  always_comb
    next_byte = rem == 3'd4 ? tx_q[31:24] :
                rem == 3'd3 ? tx_q[23:16] :
                rem == 3'd2 ? tx_q[15:8]  : tx_q[7:0];
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state          <= IDLE;
      cnt            <= '0;
      rem            <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      bus.o_SPI_CS_n <= 1'b1;
      bus.o_Busy     <= 1'b0;
      bus.o_Done     <= 1'b0;
      bus.o_TX_DV    <= 1'b0;
      bus.o_TX_Byte  <= '0;
      bus.o_RX_Word  <= '0;
    end else begin
      bus.o_Done  <= 1'b0;
      bus.o_TX_DV <= 1'b0;
      case (state)
        IDLE:
          if (bus.i_Start && bus.i_Len >= 3'd1 && bus.i_Len <= 3'd4) begin
            tx_q           <= bus.i_TX_Word;
            rem            <= bus.i_Len;
            rx_q           <= '0;
            cnt            <= '0;
            bus.o_SPI_CS_n <= 1'b0;
            bus.o_Busy     <= 1'b1;
            state          <= CS_LEAD;
          end
        CS_LEAD:
          if (cnt == 8'(CS_LEAD_CLKS - 1)) begin
            cnt   <= '0;
            state <= SEND;
          end else cnt <= cnt + 8'd1;
        SEND:
          if (bus.i_TX_Ready) begin
            bus.o_TX_DV   <= 1'b1;
            bus.o_TX_Byte <= next_byte;
            state         <= WAIT_RX;
          end
        WAIT_RX:
          if (bus.i_RX_DV) begin
            rx_q  <= {rx_q[23:0], bus.i_RX_Byte};
            rem   <= rem - 3'd1;
            cnt   <= '0;
            state <= rem == 3'd1 ? CS_LAG : SEND;
          end
        // Ready back high means the core has finished its last SPI edge
        CS_LAG:
          if (bus.i_TX_Ready) begin
            if (cnt == 8'(CS_LAG_CLKS - 1)) begin
              cnt            <= '0;
              bus.o_SPI_CS_n <= 1'b1;
              bus.o_Done     <= 1'b1;
              bus.o_RX_Word  <= rx_q;
              state          <= CS_IDLE;
            end else cnt <= cnt + 8'd1;
          end
        CS_IDLE:
          if (cnt == 8'(CS_IDLE_CLKS - 1)) begin
            cnt        <= '0;
            bus.o_Busy <= 1'b0;
            state      <= IDLE;
          end else cnt <= cnt + 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// tb_spi_xfer_ctrl: scoreboard bench for spi_xfer_ctrl with a behavioral byte core
module tb_spi_xfer_ctrl;
  localparam int LEAD = 2;
  localparam int LAG  = 2;
  localparam int IDL  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_xfer_ctrl_if ifc ();
  spi_xfer_ctrl #(.CS_LEAD_CLKS(LEAD), .CS_LAG_CLKS(LAG), .CS_IDLE_CLKS(IDL)) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus(ifc.slave)
  );
  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rx[$];
  logic [7:0]  rsp_q[$];
  logic        core_loop = 1'b1;
  int          dv_cnt = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  // Byte core: takes a byte, stays busy, returns a byte, then re-arms ready
  initial begin
    logic [7:0] b;
    ifc.i_TX_Ready = 1'b1;
    ifc.i_RX_DV    = 1'b0;
    ifc.i_RX_Byte  = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (ifc.o_TX_DV === 1'b1) begin
        b = core_loop ? ifc.o_TX_Byte : (rsp_q.size() > 0 ? rsp_q.pop_front() : 8'hEE);
        ifc.i_TX_Ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 ifc.i_RX_Byte = b;
        ifc.i_RX_DV = 1'b1;
        @(posedge clk); #1 ifc.i_RX_DV = 1'b0;
        repeat (2) @(posedge clk);
        #1 ifc.i_TX_Ready = 1'b1;
      end
    end
  end
  // Monitor: pops scoreboard on DV/Done and checks CS timing
  initial begin
    int cyc = 0, cs_fall = 0, last_done = 0;
    logic prev_cs = 1'b1, done_seen = 1'b0, lead_pend = 1'b0;
    logic [7:0] last_tx = 8'h00;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (ifc.o_Done === 1'b1 && exp_rx.size() == 0) begin
        checks++; errors++;
        $display("FAIL done_unexpected: got o_Done=1 expected 0");
      end
      if (rst) begin
        prev_cs = 1'b1;
        last_tx = ifc.o_TX_Byte;
        continue;
      end
      if (ifc.o_TX_DV === 1'b1) begin
        dv_cnt++;
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got DV byte %h expected none", ifc.o_TX_Byte);
        end else chk("tx_byte", 32'(ifc.o_TX_Byte), 32'(exp_tx.pop_front()));
        if (lead_pend) begin
          chk("cs_lead", 32'((cyc - cs_fall) >= LEAD && (cyc - cs_fall) <= LEAD + 1), 32'd1);
          lead_pend = 1'b0;
        end
        last_tx = ifc.o_TX_Byte;
      end else if (ifc.o_TX_Byte !== last_tx) begin
        checks++; errors++;
        $display("FAIL tx_hold: got %h expected %h", ifc.o_TX_Byte, last_tx);
        last_tx = ifc.o_TX_Byte;
      end
      if (ifc.o_Done === 1'b1 && exp_rx.size() > 0) begin
        chk("rx_word", ifc.o_RX_Word, exp_rx.pop_front());
        last_done = cyc;
        done_seen = 1'b1;
      end
      if (prev_cs && ifc.o_SPI_CS_n === 1'b0) begin
        cs_fall = cyc;
        lead_pend = 1'b1;
        if (done_seen) chk("cs_idle_gap", 32'((cyc - last_done) >= IDL + 1), 32'd1);
      end
      if (!prev_cs && ifc.o_SPI_CS_n === 1'b1 && ifc.o_Done !== 1'b1) begin
        checks++; errors++;
        $display("FAIL cs_rise_without_done: got CS_n=1 Done=%b expected Done=1", ifc.o_Done);
      end
      if (ifc.o_SPI_CS_n === 1'b0 && ifc.o_Busy !== 1'b1) begin
        checks++; errors++;
        $display("FAIL busy_with_cs: got Busy=%b expected 1", ifc.o_Busy);
      end
      prev_cs = ifc.o_SPI_CS_n;
    end
  end
  task automatic pulse_start(logic [2:0] len, logic [31:0] word);
    @(posedge clk); #2;
    ifc.i_Len = len;
    ifc.i_TX_Word = word;
    ifc.i_Start = 1'b1;
    @(posedge clk); #2 ifc.i_Start = 1'b0;
  endtask
  task automatic xfer(logic [2:0] len, logic [31:0] word, logic [31:0] bytes, logic [31:0] rx, logic loop);
    logic [31:0] t;
    t = bytes;
    core_loop = loop;
    for (int k = 0; k < int'(len); k++) exp_tx.push_back(t[8*(int'(len)-k)-1 -: 8]);
    exp_rx.push_back(rx);
    pulse_start(len, word);
  endtask
  task automatic wait_idle(string n);
    int c = 0;
    while ((ifc.o_Busy === 1'b1 || exp_rx.size() > 0) && c < 2000) begin
      @(posedge clk); #2;
      c++;
    end
    if (c >= 2000) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", n, c);
    end
  endtask
  task automatic wait_dv(int target);
    int c = 0;
    while (dv_cnt < target && c < 500) begin
      @(posedge clk); #2;
      c++;
    end
    if (c >= 500) begin
      checks++; errors++;
      $display("FAIL dv_timeout: got %0d DVs expected %0d", dv_cnt, target);
    end
  endtask
  initial begin
    int c;
    ifc.i_Start = 1'b0;
    ifc.i_Len = 3'd0;
    ifc.i_TX_Word = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_cs_n", 32'(ifc.o_SPI_CS_n), 32'd1);
    chk("rst_busy", 32'(ifc.o_Busy), 32'd0);
    chk("rst_done", 32'(ifc.o_Done), 32'd0);
    chk("rst_tx_dv", 32'(ifc.o_TX_DV), 32'd0);
    chk("rst_tx_byte", 32'(ifc.o_TX_Byte), 32'h0);
    chk("rst_rx_word", ifc.o_RX_Word, 32'h0);
    rst = 1'b0;
    xfer(3'd1, 32'h000000A5, 32'h000000A5, 32'h000000A5, 1'b1);
    wait_idle("len1");
    xfer(3'd4, 32'h11223344, 32'h11223344, 32'h11223344, 1'b1);
    wait_idle("len4");
    rsp_q.push_back(8'h01); rsp_q.push_back(8'h02); rsp_q.push_back(8'h03);
    xfer(3'd3, 32'hFFAABBCC, 32'h00AABBCC, 32'h00010203, 1'b0);
    wait_idle("len3");
    repeat (5) @(posedge clk);
    #2 chk("rx_hold", ifc.o_RX_Word, 32'h00010203);
    core_loop = 1'b1;
    pulse_start(3'd0, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #2 chk("len0_busy", 32'(ifc.o_Busy), 32'd0);
    chk("len0_cs", 32'(ifc.o_SPI_CS_n), 32'd1);
    pulse_start(3'd5, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #2 chk("len5_busy", 32'(ifc.o_Busy), 32'd0);
    chk("len5_cs", 32'(ifc.o_SPI_CS_n), 32'd1);
    chk("len5_rx_word", ifc.o_RX_Word, 32'h00010203);
    c = dv_cnt;
    xfer(3'd4, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 1'b1);
    wait_dv(c + 2);
    pulse_start(3'd1, 32'h0000005A);
    exp_tx.push_back(8'hBE); exp_tx.push_back(8'hEF);
    exp_rx.push_back(32'h0000BEEF);
    #1 ifc.i_Len = 3'd2;
    ifc.i_TX_Word = 32'h0000BEEF;
    ifc.i_Start = 1'b1;
    c = 0;
    while (exp_rx.size() > 1 && c < 2000) begin
      @(posedge clk); #2;
      c++;
    end
    while (ifc.o_SPI_CS_n !== 1'b0 && c < 2000) begin
      @(posedge clk); #2;
      c++;
    end
    if (c >= 2000) begin
      checks++; errors++;
      $display("FAIL held_start_timeout: got no restart after %0d cycles expected restart", c);
    end
    ifc.i_Start = 1'b0;
    wait_idle("held_start");
    c = dv_cnt;
    xfer(3'd4, 32'h01020304, 32'h01020304, 32'h01020304, 1'b1);
    wait_dv(c + 2);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk("midrst_cs_n", 32'(ifc.o_SPI_CS_n), 32'd1);
    chk("midrst_busy", 32'(ifc.o_Busy), 32'd0);
    chk("midrst_done", 32'(ifc.o_Done), 32'd0);
    exp_tx.delete();
    exp_rx.delete();
    @(posedge clk); #3 rst = 1'b0;
    c = 0;
    while (ifc.i_TX_Ready !== 1'b1 && c < 100) begin
      @(posedge clk); #2;
      c++;
    end
    repeat (10) @(posedge clk);
    #2 chk("postrst_done", 32'(ifc.o_Done), 32'd0);
    chk("postrst_rx_word", ifc.o_RX_Word, 32'h0);
    xfer(3'd1, 32'h0000003C, 32'h0000003C, 32'h0000003C, 1'b1);
    wait_idle("postrst");
    chk("final_exp_tx_empty", 32'(exp_tx.size()), 32'd0);
    chk("final_cs_n", 32'(ifc.o_SPI_CS_n), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
